// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decipher datapath.
// Holds the state and word widths, the 128-bit state type and the
// encoding of the InvSubBytes arbiter FSM.
package aes_dec_pkg;

  localparam int STATE_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_STATE = 4;

  typedef logic [STATE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ISB_IDLE,
    ISB_SUB,
    ISB_RESP
  } isb_fsm_e;

endpackage

// File: rtl/inv_sub_bytes_arbiter_sbox.sv
// sBox: four parallel AES inverse S-box lookups on one 32-bit word.
// Ports:
//   din  - 32-bit input word, four independent bytes
//   dout - 32-bit output word, each byte replaced by InvSbox(byte)
// Purely combinational.
module sBox (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Table entry for byte value v sits at bits [2047-8*v -: 8].
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_byte(input logic [7:0] b);
    return INV_TABLE[(255 - int'(b))*8 +: 8];
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      dout[8*i +: 8] = inv_byte(din[8*i +: 8]);
    end
  end

endmodule

// File: rtl/inv_sub_bytes_arbiter.sv
// inv_sub_bytes_arbiter: shares one 32-bit inverse S-box between NUM_REQ
// requesters. A round-robin grant accepts one full 128-bit state, the
// four words are substituted one per cycle (MSW first), and the result
// is returned together with the owning requester's index.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   flush                - synchronous abort of the in-flight job
//   req_valid/req_ready  - per-requester handshake (ready is one-hot or 0)
//   req_data             - requester i state at [i*128 +: 128]
//   rsp_valid/rsp_ready  - result handshake
//   rsp_data, rsp_id     - substituted state and owning requester
module inv_sub_bytes_arbiter
  import aes_dec_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*STATE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [STATE_W-1:0]         rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  input  logic                       rsp_ready
);

  isb_fsm_e    fsm_q, fsm_d;
  logic [1:0]  wcnt;
  aes_state_t  state_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic        accept;
  logic [WORD_W-1:0] sub_in, sub_out;

  // First valid requester searching upward from last+1, wrapping. The
  // loop runs from the farthest candidate down so the nearest one wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    int idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (v[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign sub_in   = state_q[(WORDS_PER_STATE-1-int'(wcnt))*WORD_W +: WORD_W];
  assign rsp_data = state_q;
  assign rsp_id   = id_q;

  sBox u_sbox (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Grant, ready and next-state decode. req_ready is also gated by rst_n
  // so it reads 0 for the whole time reset is held.
  always_comb begin
    fsm_d     = fsm_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    grant     = rr_pick(req_valid, last_grant);
    case (fsm_q)
      ISB_IDLE: begin
        if (rst_n && !flush && (|req_valid)) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          fsm_d            = ISB_SUB;
        end
      end
      ISB_SUB: begin
        if (flush)
          fsm_d = ISB_IDLE;
        else if (wcnt == 2'(WORDS_PER_STATE-1))
          fsm_d = ISB_RESP;
      end
      ISB_RESP: begin
        rsp_valid = 1'b1;
        if (flush || rsp_ready)
          fsm_d = ISB_IDLE;
      end
      default: fsm_d = ISB_IDLE;
    endcase
  end

  // State register and datapath. A flushed job simply leaves its partial
  // data behind; last_grant only moves on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ISB_IDLE;
      wcnt       <= '0;
      state_q    <= '0;
      id_q       <= '0;
      last_grant <= ID_W'(NUM_REQ-1);
    end else begin
      fsm_q <= fsm_d;
      if (accept) begin
        state_q    <= req_data[int'(grant)*STATE_W +: STATE_W];
        id_q       <= grant;
        last_grant <= grant;
        wcnt       <= '0;
      end else if (fsm_q == ISB_SUB && !flush) begin
        state_q[(WORDS_PER_STATE-1-int'(wcnt))*WORD_W +: WORD_W] <= sub_out;
        wcnt <= wcnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_arbiter.sv
module tb_inv_sub_bytes_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [127:0]         rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_ready;

  int pass_count  = 0;
  int check_count = 0;
  int cyc         = 0;
  int tb_last     = NUM_REQ - 1;
  int accept_cyc  = 0;

  logic [7:0] inv_tab [256];

  typedef struct {
    int           port;
    logic [127:0] data;
    logic [127:0] expected;
  } vec_t;

  vec_t vecs [6];

  inv_sub_bytes_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // GF(2^8) multiply with the AES polynomial, used to rebuild the S-box.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Forward S-box from field inverse + affine map, then inverted.
  task automatic buildModel();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] invState(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Present a request on one port (called at posedge+1) and complete its
  // handshake. Returns how many cycles passed before ready was seen.
  task automatic applyStimulus(input int port, input logic [127:0] data,
                               input string name, output int wait_n);
    int n = 0;
    req_valid[port] = 1'b1;
    req_data[port*128 +: 128] = data;
    #1;
    while (!req_ready[port] && n < 30) begin
      @(posedge clk); #2;
      n++;
    end
    wait_n = n;
    checkOutput({name, "_grant"}, 128'(req_ready), 128'(1 << port));
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    req_valid[port] = 1'b0;
    tb_last = port;
  endtask

  // Wait for rsp_valid (sampled 1ns after each edge) and check the result.
  task automatic awaitResponse(input logic [127:0] exp, input int exp_id, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rsp_valid && n < 20);
    checkOutput({name, "_latency"}, 128'(n), 128'd4);
    checkOutput({name, "_data"}, rsp_data, exp);
    checkOutput({name, "_id"}, 128'(rsp_id), 128'(exp_id));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w, p, prev_acc;
    logic [127:0] cap_data, d;
    logic [ID_W-1:0] cap_id;
    bit stable_ok, ready_ok, none_ok;

    buildModel();
    vecs[0] = '{0, 128'h0, {16{8'h52}}};
    vecs[1] = '{1, {4{32'h6300ff01}}, {4{32'h00527d09}}};
    vecs[2] = '{0, {16{8'h09}}, {16{8'h40}}};
    vecs[3] = '{1, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
    vecs[4] = '{0, {16{8'h63}}, 128'h0};
    vecs[5] = '{1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, invState(128'h3ad77bb40d7a3660a89ecaf32466ef97)};

    // Reset state, with a request pending so ready gating is exercised.
    rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_data = '0;
    req_valid[0] = 1'b1;
    #3;
    checkOutput("reset_rsp_valid", 128'(rsp_valid), 128'd0);
    checkOutput("reset_req_ready", 128'(req_ready), 128'd0);
    checkOutput("reset_rsp_data", rsp_data, 128'd0);
    checkOutput("reset_rsp_id", 128'(rsp_id), 128'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven single jobs.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].port, vecs[i].data, $sformatf("vec%0d", i), w);
      awaitResponse(vecs[i].expected, vecs[i].port, $sformatf("vec%0d", i));
    end

    // Arbitration: both ports continuously valid for 8 jobs.
    req_data[0 +: 128]   = {16{8'h10}};
    req_data[128 +: 128] = {16{8'h11}};
    req_valid = 2'b11;
    prev_acc = 0;
    for (int j = 0; j < 8; j++) begin
      p = (tb_last + 1) % NUM_REQ;
      d = req_data[p*128 +: 128];
      applyStimulus(p, d, $sformatf("arb%0d", j), w);
      if (j > 0) checkOutput($sformatf("arb%0d_spacing", j), 128'(accept_cyc - prev_acc), 128'd6);
      prev_acc = accept_cyc;
      req_data[p*128 +: 128] = {16{8'(8'h20 + 8'(j*29))}};
      req_valid[p] = 1'b1;
      awaitResponse(invState(d), p, $sformatf("arb%0d", j));
    end
    req_valid = '0;
    @(posedge clk); #1;

    // Backpressure: result held for 10 cycles, no grants meanwhile.
    rsp_ready = 1'b0;
    p = (tb_last + 1) % NUM_REQ;
    applyStimulus(p, 128'hdeadbeef0123456789abcdeffedcba98, "bp", w);
    awaitResponse(invState(128'hdeadbeef0123456789abcdeffedcba98), p, "bp");
    cap_data = rsp_data; cap_id = rsp_id;
    req_valid[1-p] = 1'b1;
    req_data[(1-p)*128 +: 128] = {8{16'h7c7c}};
    stable_ok = 1'b1; ready_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== cap_data || rsp_id !== cap_id) stable_ok = 1'b0;
      if (req_ready !== '0) ready_ok = 1'b0;
    end
    checkOutput("bp_stable", 128'(stable_ok), 128'd1);
    checkOutput("bp_no_ready", 128'(ready_ok), 128'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_released", 128'(rsp_valid), 128'd0);
    applyStimulus(1 - p, {8{16'h7c7c}}, "bp_next", w);
    checkOutput("bp_idle_next", 128'(w), 128'd0);
    awaitResponse(invState({8{16'h7c7c}}), 1 - p, "bp_next");
    @(posedge clk); #1;

    // Flush on the second SUB cycle.
    p = (tb_last + 1) % NUM_REQ;
    applyStimulus(p, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, "fl", w);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    none_ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) none_ok = 1'b0;
    end
    checkOutput("fl_no_rsp", 128'(none_ok), 128'd1);

    // Flush in IDLE blocks acceptance.
    req_valid[0] = 1'b1; flush = 1'b1;
    #1;
    checkOutput("fl_idle_block", 128'(req_ready), 128'd0);
    req_valid = '0; flush = 1'b0;
    @(posedge clk); #1;

    // After a flush the next port in order wins even with both valid.
    req_valid = 2'b11;
    req_data[p*128 +: 128] = {16{8'h00}};
    applyStimulus(1 - p, 128'h8c8c8c8c000000006363636301010101, "fl_next", w);
    req_valid = '0;
    awaitResponse(invState(128'h8c8c8c8c000000006363636301010101), 1 - p, "fl_next");
    @(posedge clk); #1;

    // Async reset mid-SUB, between clock edges.
    p = (tb_last + 1) % NUM_REQ;
    applyStimulus(p, 128'h11223344556677889900aabbccddeeff, "rst", w);
    @(posedge clk); #3;
    req_valid[1-p] = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_data", rsp_data, 128'd0);
    checkOutput("rst_async_valid", 128'(rsp_valid), 128'd0);
    checkOutput("rst_async_ready", 128'(req_ready), 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tb_last = NUM_REQ - 1;
    req_valid = 2'b11;
    req_data[0 +: 128]   = {16{8'h4a}};
    req_data[128 +: 128] = {16{8'h4b}};
    applyStimulus(0, {16{8'h4a}}, "rst_first", w);
    req_valid = '0;
    awaitResponse(invState({16{8'h4a}}), 0, "rst_first");

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
